// File: rtl/synch_fifo.sv
// Single-clock FIFO with registered read data and pointer-derived full/empty flags.
// Define SYNCH_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module synch_fifo #(
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned data_size  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chip_select,
  input  logic                 read_enable,
  input  logic                 write_enable,
  input  logic [data_size-1:0] data_in,
  output logic [data_size-1:0] data_out,
  output logic                 fifo_full,
  output logic                 fifo_empty
`ifdef SYNCH_FIFO_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int unsigned address_bits = $clog2(fifo_depth);

  logic [data_size-1:0]  mem [fifo_depth];
  logic [address_bits:0] write_address;
  logic [address_bits:0] read_address;
  logic                  write_accept;
  logic                  read_accept;

  // MSB is a wrap bit: equal pointers mean empty, opposite wrap with same index means full
  assign fifo_empty = (write_address == read_address);
  assign fifo_full  = (write_address[address_bits] != read_address[address_bits]) &&
                      (write_address[address_bits-1:0] == read_address[address_bits-1:0]);

  assign write_accept = chip_select & write_enable & ~fifo_full;
  assign read_accept  = chip_select & read_enable  & ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_address <= '0;
      read_address  <= '0;
      data_out      <= '0;
    end else begin
      if (write_accept) begin
        write_address <= write_address + (address_bits+1)'(1);
      end
      if (read_accept) begin
        read_address <= read_address + (address_bits+1)'(1);
        data_out     <= mem[read_address[address_bits-1:0]];
      end
    end
  end

  // Storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (write_accept) begin
      mem[write_address[address_bits-1:0]] <= data_in;
    end
  end

`ifdef SYNCH_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (chip_select & write_enable & fifo_full) begin
        overflow <= 1'b1;
      end
      if (chip_select & read_enable & fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_synch_fifo.sv
// Self-checking bench for synch_fifo: directed scenarios plus random traffic against a queue model.
module tb_synch_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AB    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          chip_select;
  logic          read_enable;
  logic          write_enable;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          fifo_full;
  logic          fifo_empty;
`ifdef SYNCH_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, pointers as total accepted-operation counts
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  int            wcount;
  int            rcount;
  bit            exp_ovf;
  bit            exp_unf;
  logic [AB:0]   exp_wa;
  logic [AB:0]   exp_ra;

  synch_fifo #(.fifo_depth(DEPTH), .data_size(DW)) dut (
    .clk(clk),
    .reset(reset),
    .chip_select(chip_select),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .data_in(data_in),
    .data_out(data_out),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
`ifdef SYNCH_FIFO_ERR_FLAGS_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    model_q.delete();
    exp_dout = '0;
    wcount   = 0;
    rcount   = 0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  task automatic update_exp_ptrs();
    exp_wa = (AB+1)'(wcount % (2*DEPTH));
    exp_ra = (AB+1)'(rcount % (2*DEPTH));
  endtask

  // Drive one clock of stimulus and advance the model; returns #1 after the edge
  task automatic cycle(input bit cs, input bit re, input bit we, input logic [DW-1:0] din);
    bit full_m;
    bit empty_m;
    @(negedge clk);
    chip_select  = cs;
    read_enable  = re;
    write_enable = we;
    data_in      = din;
    @(posedge clk);
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    if (cs && re && !empty_m) begin
      exp_dout = model_q.pop_front();
      rcount++;
    end
    if (cs && we && !full_m) begin
      model_q.push_back(din);
      wcount++;
    end
    if (cs && we && full_m) exp_ovf = 1'b1;
    if (cs && re && empty_m) exp_unf = 1'b1;
    update_exp_ptrs();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    chip_select  = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    model_reset();
    update_exp_ptrs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    chip_select  = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    data_in      = '0;
    model_reset();
    update_exp_ptrs();
    #3;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: empty=%b full=%b, required 1/0", fifo_empty, fifo_full);
    end
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL reset_dout: got %0d, required 0", data_out);
    end
    checks++;
    if (dut.write_address !== '0 || dut.read_address !== '0) begin
      errors++; $display("FAIL reset_ptrs: wa=%0d ra=%0d, required 0/0", dut.write_address, dut.read_address);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [3] = '{32'd1, 32'd10, 32'd100};
    foreach (vals[i]) cycle(1, 0, 1, vals[i]);
    foreach (vals[i]) begin
      cycle(1, 1, 0, '0);
      checks++;
      if (data_out !== vals[i]) begin
        errors++; $display("FAIL basic_read%0d: got %0d, required %0d", i, data_out, vals[i]);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++; $display("FAIL basic_empty: got %b, required 1", fifo_empty);
    end
  endtask

  task automatic test_interleaved();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, DW'(1 << i));
      checks++;
      if (dut.write_address !== (AB+1)'(i + 1) || fifo_empty !== 1'b0) begin
        errors++; $display("FAIL inter_write%0d: wa=%0d empty=%b, required %0d/0", i, dut.write_address, fifo_empty, i + 1);
      end
      cycle(1, 1, 0, '0);
      checks++;
      if (data_out !== DW'(1 << i) || fifo_empty !== 1'b1 || dut.read_address !== (AB+1)'(i + 1)) begin
        errors++; $display("FAIL inter_read%0d: dout=%0d empty=%b ra=%0d, required %0d/1/%0d",
                           i, data_out, fifo_empty, dut.read_address, 1 << i, i + 1);
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic [AB:0] wa_before;
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, DW'(1 << i));
    checks++;
    if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
      errors++; $display("FAIL fill_full: full=%b empty=%b, required 1/0", fifo_full, fifo_empty);
    end
    wa_before = dut.write_address;
    cycle(1, 0, 1, 32'd16);
    checks++;
    if (dut.write_address !== exp_wa || fifo_full !== 1'b1) begin
      errors++; $display("FAIL overflow_ptr: wa=%0d full=%b, required %0d/1", dut.write_address, fifo_full, exp_wa);
    end
`ifdef SYNCH_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_flag: got %b, required 1", overflow);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, '0);
      checks++;
      if (data_out !== DW'(1 << i)) begin
        errors++; $display("FAIL fill_read%0d: got %0d, required %0d (wa before drop %0d)", i, data_out, 1 << i, wa_before);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++; $display("FAIL fill_empty: got %b, required 1", fifo_empty);
    end
  endtask

  task automatic test_underflow();
    cycle(1, 1, 0, '0);
    checks++;
    if (data_out !== 32'd8 || dut.read_address !== exp_ra || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL underflow_hold: dout=%0d ra=%0d empty=%b, required 8/%0d/1", data_out, dut.read_address, fifo_empty, exp_ra);
    end
`ifdef SYNCH_FIFO_ERR_FLAGS_EN
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_flag: got %b, required 1", underflow);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [DW-1:0] vals [4] = '{32'd0, 32'd1, 32'd4, 32'd9};
    foreach (vals[i]) begin
      cycle(1, 0, 1, vals[i]);
      cycle(0, 0, 1, 32'hdead);
      checks++;
      if (fifo_empty !== (model_q.size() == 0) || fifo_full !== (model_q.size() == DEPTH) ||
          dut.write_address !== exp_wa) begin
        errors++; $display("FAIL wrap_wflags%0d: empty=%b full=%b wa=%0d, required %b/%b/%0d", i,
                           fifo_empty, fifo_full, dut.write_address, model_q.size() == 0, model_q.size() == DEPTH, exp_wa);
      end
    end
    foreach (vals[i]) begin
      cycle(1, 1, 0, '0);
      checks++;
      if (data_out !== vals[i]) begin
        errors++; $display("FAIL wrap_read%0d: got %0d, required %0d", i, data_out, vals[i]);
      end
      cycle(1, 0, 0, '0);
      checks++;
      if (fifo_empty !== (model_q.size() == 0) || fifo_full !== 1'b0 || dut.read_address !== exp_ra) begin
        errors++; $display("FAIL wrap_rflags%0d: empty=%b full=%b ra=%0d, required %b/0/%0d", i,
                           fifo_empty, fifo_full, dut.read_address, model_q.size() == 0, exp_ra);
      end
    end
  endtask

  task automatic test_gating_reset();
    cycle(0, 1, 1, 32'd77);
    checks++;
    if (fifo_empty !== 1'b1 || dut.write_address !== exp_wa) begin
      errors++; $display("FAIL gate_write: empty=%b wa=%0d, required 1/%0d", fifo_empty, dut.write_address, exp_wa);
    end
    cycle(1, 0, 1, 32'd21);
    cycle(1, 0, 1, 32'd22);
    cycle(1, 1, 0, '0);
    cycle(1, 0, 1, 32'd23);
    cycle(0, 0, 0, '0);
    // Reset pulse lands between edges with two entries stored
    #2;
    reset = 1'b1;
    model_reset();
    update_exp_ptrs();
    #1;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || data_out !== '0) begin
      errors++; $display("FAIL async_reset: empty=%b full=%b dout=%0d, required 1/0/0", fifo_empty, fifo_full, data_out);
    end
    #1;
    reset = 1'b0;
    cycle(1, 0, 1, 32'd55);
    cycle(1, 1, 0, '0);
    checks++;
    if (data_out !== 32'd55 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL post_reset_read: dout=%0d empty=%b, required 55/1", data_out, fifo_empty);
    end
  endtask

  task automatic test_random();
    bit cs;
    bit re;
    bit we;
    for (int n = 0; n < 400; n++) begin
      cs = ($urandom_range(0, 9) != 0);
      re = ($urandom_range(0, 1) != 0);
      we = ($urandom_range(0, 2) != 0) ^ (n[6] == 1'b1);
      cycle(cs, re, we, $urandom);
      checks++;
      if (data_out !== exp_dout || fifo_empty !== (model_q.size() == 0) ||
          fifo_full !== (model_q.size() == DEPTH) ||
          dut.write_address !== exp_wa || dut.read_address !== exp_ra) begin
        errors++; $display("FAIL random%0d: dout=%h empty=%b full=%b wa=%0d ra=%0d, required %h/%b/%b/%0d/%0d",
                           n, data_out, fifo_empty, fifo_full, dut.write_address, dut.read_address,
                           exp_dout, model_q.size() == 0, model_q.size() == DEPTH, exp_wa, exp_ra);
      end
    end
`ifdef SYNCH_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== exp_ovf || underflow !== exp_unf) begin
      errors++; $display("FAIL random_err_flags: ovf=%b unf=%b, required %b/%b", overflow, underflow, exp_ovf, exp_unf);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleaved();
    test_fill_overflow();
    test_underflow();
    test_wrap();
    test_gating_reset();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
